multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
- clk  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- Opcode  in  6  instruction[31:26] from the instruction register.
- MemReady  in  1  memory handshake; 1 = the current read or write completes this cycle.
- PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA  out  1 each  datapath strobes and selects.
- ALUSrcB  out  2  ALU B select: 00=reg B, 01=constant 4, 10=sign-extended immediate, 11=immediate<<2.
- PCSource  out  2  PC input select: 00=ALU result, 01=ALUOut register, 10=jump target.
- ALUOp  out  4  operation class sent to the ALU control decoder.
- IllegalOp  out  1  one-cycle pulse when an unsupported opcode is decoded.
- InstrCount  out  16  count of retired instructions.
- State  out  4  current state code, for debug only.

Function
REQ-002 The block SHALL be a Moore FSM: every output except InstrCount SHALL decode only from the state register, plus the latched opcode (OpReg) and MemReady where noted below.
REQ-003 The state codes SHALL be: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, REXEC=7, RWB=8, IEXEC=9, IWB=10, BRANCH=11, JUMP=12. Codes 13-15 are illegal and SHALL go to FETCH on the next edge.
REQ-004 Any output not listed for a state SHALL be 0.
REQ-005 The ALUOp encodings SHALL be: R-type=1111, ADD (ADDI, PC and branch-target arithmetic)=0100, ORI=0101, LUI=0110, LW=0001, SW=0010, branch compare=0011.
REQ-006 IDLE: all outputs 0; IDLE SHALL always go to FETCH on the next edge.
REQ-007 FETCH:
- Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=0100, PCSource=00.
- IRWrite and PCWrite SHALL each equal MemReady.
- The FSM SHALL stay in FETCH while MemReady=0 and go to DECODE when MemReady=1.
REQ-008 DECODE:
- Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=0100.
- OpReg SHALL load Opcode on this edge.
- Next state by Opcode: 000000 -> REXEC; 100011 (LW) and 101011 (SW) -> MEMADR; 001000 (ADDI), 001101 (ORI), 001111 (LUI) -> IEXEC; 000100 (BEQ), 000101 (BNE) -> BRANCH; 000010 (J) -> JUMP.
- Any other opcode SHALL go to FETCH with IllegalOp=1 for exactly that DECODE cycle.
REQ-009 MEMADR:
- Outputs: ALUSrcA=1, ALUSrcB=10; ALUOp=0001 if OpReg=LW, else 0010.
- Next state: MEMRD for LW, MEMWR for SW.
REQ-010 MEMRD:
- Outputs: MemRead=1, IorD=1.
- Stay while MemReady=0; go to MEMWB when MemReady=1.
REQ-011 MEMWB: outputs RegWrite=1, RegDst=0, MemtoReg=1; next state FETCH.
REQ-012 MEMWR:
- Outputs: MemWrite=1, IorD=1.
- Stay while MemReady=0; go to FETCH when MemReady=1.
REQ-013 REXEC: outputs ALUSrcA=1, ALUSrcB=00, ALUOp=1111; next state RWB.
REQ-014 RWB: outputs RegWrite=1, RegDst=1, MemtoReg=0; next state FETCH.
REQ-015 IEXEC:
- Outputs: ALUSrcA=1, ALUSrcB=10; ALUOp=0100, 0101 or 0110 for ADDI, ORI or LUI respectively.
- Next state IWB.
REQ-016 IWB: outputs RegWrite=1, RegDst=0, MemtoReg=0; next state FETCH.
REQ-017 BRANCH:
- Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=0011, PCWriteCond=1, PCSource=01; BranchNE=1 only when OpReg=000101.
- Next state FETCH.
REQ-018 JUMP: outputs PCWrite=1, PCSource=10; next state FETCH.
REQ-019 InstrCount SHALL increment by 1 on each edge that leaves MEMWB, MEMWR (with MemReady=1), RWB, IWB, BRANCH or JUMP.
REQ-020 InstrCount SHALL wrap from FFFF to 0000.
REQ-021 InstrCount SHALL NOT increment on the illegal-opcode path.
REQ-022 Instruction latency SHALL be, with MemReady held at 1: R-type, I-type and SW = 4 cycles; LW = 5 cycles; BEQ, BNE and J = 3 cycles. Each memory wait cycle SHALL add exactly 1 cycle.

Reset
REQ-023 While reset=0, the following SHALL hold immediately, independent of clk:
- state=IDLE, so all decoded outputs are 0;
- OpReg=000000;
- InstrCount=0.
REQ-024 Asserting reset during any state, including FETCH, MEMRD or MEMWR while waiting on MemReady, SHALL abort the instruction with no further strobes. InstrCount SHALL NOT change.
REQ-025 After reset is released, the first rising edge SHALL move IDLE -> FETCH.

Verification
REQ-026 The bench SHALL cover these scenarios:
- Reset, release, MemReady=1, Opcode=000000: State sequence 0,1,2,7,8,1; RegWrite=1 with RegDst=1 in state 8; InstrCount=1.
- LW (100011) with MemReady=0 for 2 cycles in MEMRD: State stays 4 for 3 cycles; ALUOp=0001 in MEMADR; MemtoReg=1 in MEMWB; InstrCount increments once.
- BNE (000101): in state 11, ALUOp=0011, PCWriteCond=1 and BranchNE=1; BEQ (000100) gives BranchNE=0; each takes 3 cycles.
- Opcode=111111: IllegalOp=1 for one cycle in DECODE, next state FETCH, InstrCount unchanged.
- Reset pulled low mid-MEMWR with MemReady=0: MemWrite drops to 0 immediately and State=0; after release, FETCH follows one edge later.
- Force InstrCount to FFFF, then retire J (000010): InstrCount=0000 and PCWrite=1 with PCSource=10 in JUMP.

Source files
------------

// File: rtl/multicycle_control.sv
// Control FSM for a multicycle MIPS-style datapath: sequences fetch, decode,
// execute, memory and write-back steps and counts retired instructions.
module multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  Opcode,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        BranchNE,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        MemtoReg,
  output logic        RegDst,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSource,
  output logic [3:0]  ALUOp,
  output logic        IllegalOp,
  output logic [15:0] InstrCount,
  output logic [3:0]  State
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,  S_MEMWB = 4'd5,  S_MEMWR  = 4'd6,  S_REXEC  = 4'd7,
    S_RWB    = 4'd8,  S_IEXEC = 4'd9,  S_IWB    = 4'd10, S_BRANCH = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [3:0] ALU_RTYPE = 4'b1111;
  localparam logic [3:0] ALU_ADD   = 4'b0100;
  localparam logic [3:0] ALU_ORI   = 4'b0101;
  localparam logic [3:0] ALU_LUI   = 4'b0110;
  localparam logic [3:0] ALU_LW    = 4'b0001;
  localparam logic [3:0] ALU_SW    = 4'b0010;
  localparam logic [3:0] ALU_BR    = 4'b0011;

  state_t      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [15:0] count_q, count_d;
  logic        retire;

  // Codes 13-15 and IDLE both fall into the FETCH default.
  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH:  state_d = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Opcode)
          OP_RTYPE:              state_d = S_REXEC;
          OP_LW, OP_SW:          state_d = S_MEMADR;
          OP_ADDI, OP_ORI, OP_LUI: state_d = S_IEXEC;
          OP_BEQ, OP_BNE:        state_d = S_BRANCH;
          OP_J:                  state_d = S_JUMP;
          default:               state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = MemReady ? S_FETCH : S_MEMWR;
      S_REXEC:  state_d = S_RWB;
      S_IEXEC:  state_d = S_IWB;
      default:  state_d = S_FETCH;
    endcase
  end

  assign op_d    = (state_q == S_DECODE) ? Opcode : op_q;
  assign retire  = (state_q inside {S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP}) ||
                   ((state_q == S_MEMWR) && MemReady);
  assign count_d = count_q + {15'd0, retire};

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= 6'd0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      count_q <= count_d;
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred
  // and unlisted outputs read 0 in each state.
  always_comb begin
    PCWrite = 1'b0; PCWriteCond = 1'b0; BranchNE = 1'b0; IorD = 1'b0;
    MemRead = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0; MemtoReg = 1'b0;
    RegDst = 1'b0; RegWrite = 1'b0; ALUSrcA = 1'b0; ALUSrcB = 2'b00;
    PCSource = 2'b00; ALUOp = 4'b0000; IllegalOp = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1; ALUSrcB = 2'b01; ALUOp = ALU_ADD;
        IRWrite = MemReady; PCWrite = MemReady;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11; ALUOp = ALU_ADD;
        IllegalOp = !(Opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_ORI,
                                     OP_LUI, OP_BEQ, OP_BNE, OP_J});
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b10;
        ALUOp = (op_q == OP_LW) ? ALU_LW : ALU_SW;
      end
      S_MEMRD:  begin MemRead = 1'b1; IorD = 1'b1; end
      S_MEMWB:  begin RegWrite = 1'b1; MemtoReg = 1'b1; end
      S_MEMWR:  begin MemWrite = 1'b1; IorD = 1'b1; end
      S_REXEC:  begin ALUSrcA = 1'b1; ALUOp = ALU_RTYPE; end
      S_RWB:    begin RegWrite = 1'b1; RegDst = 1'b1; end
      S_IEXEC: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b10;
        ALUOp = (op_q == OP_ORI) ? ALU_ORI : (op_q == OP_LUI) ? ALU_LUI : ALU_ADD;
      end
      S_IWB:    RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA = 1'b1; ALUOp = ALU_BR; PCWriteCond = 1'b1; PCSource = 2'b01;
        BranchNE = (op_q == OP_BNE);
      end
      S_JUMP:   begin PCWrite = 1'b1; PCSource = 2'b10; end
      default: ;
    endcase
  end

  assign InstrCount = count_q;
  assign State      = state_q;

endmodule
